// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, byte/half/word accesses to a
// word-addressed data memory, partial stores done as read-modify-write.
module load_store_unit (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} lsuState_t;

  lsuState_t   state;
  logic        readyQ;
  logic        writeQ;
  logic [1:0]  sizeQ;
  logic        signedQ;
  logic [31:0] addressQ;
  logic [31:0] wdataQ;
  logic [31:0] wordQ;
  logic [31:0] rdataQ;
  logic        misaligned;

  function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        sext);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    byteVal = word[{lane, 3'b000} +: 8];
    halfVal = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return {{24{sext & byteVal[7]}}, byteVal};
      2'b01:   return {{16{sext & halfVal[15]}}, halfVal};
      default: return word;
    endcase
  endfunction

  // Only the addressed lane(s) of the captured word are overwritten.
  function automatic logic [31:0] mergeStore(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size,
                                             input logic [31:0] data);
    logic [31:0] merged;
    merged = word;
    case (size)
      2'b00: merged[{lane, 3'b000} +: 8] = data[7:0];
      2'b01: begin
        if (lane[1]) merged[31:16] = data[15:0];
        else         merged[15:0]  = data[15:0];
      end
      default: merged = data;
    endcase
    return merged;
  endfunction

  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_address[0]) ||
                      (req_size == 2'b10 && req_address[1:0] != 2'b00);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      readyQ   <= 1'b0;
      writeQ   <= 1'b0;
      sizeQ    <= 2'b00;
      signedQ  <= 1'b0;
      addressQ <= 32'h0;
      wdataQ   <= 32'h0;
      wordQ    <= 32'h0;
      rdataQ   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && readyQ) begin
            writeQ   <= req_write;
            sizeQ    <= req_size;
            signedQ  <= req_signed;
            addressQ <= req_address;
            wdataQ   <= req_wdata;
            readyQ   <= 1'b0;
            if (misaligned)                          state <= ERR;
            else if (req_write && req_size == 2'b10) state <= WR;
            else                                     state <= RD;
          end else begin
            readyQ <= 1'b1;
          end
        end
        RD: begin
          wordQ <= mem_read_data;
          if (writeQ) begin
            state <= WR;
          end else begin
            rdataQ <= extractLoad(mem_read_data, addressQ[1:0], sizeQ, signedQ);
            state  <= RESP;
          end
        end
        WR: state <= RESP;
        RESP, ERR: begin
          state  <= IDLE;
          readyQ <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          readyQ <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = readyQ;
  assign mem_read       = (state == RD);
  assign mem_write      = (state == WR);
  assign resp_valid     = (state == RESP) || (state == ERR);
  assign resp_error     = (state == ERR);
  assign resp_rdata     = rdataQ;
  assign mem_address    = {2'b00, addressQ[31:2]};
  assign mem_write_data = mergeStore(wordQ, addressQ[1:0], sizeQ, wdataQ);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory attached.
module tb_load_store_unit;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] memArray [0:15];
  logic        tbInit;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] latency, respErr, respData, rdCount, wrCount;
  logic [31:0] lastWriteData, strobeAddr, addrUnstable, bothStrobes;

  load_store_unit dut (
    .clock_in       (clock_in),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_address    (req_address),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clock_in = ~clock_in;

  // Data memory: combinational read, write on the rising edge of a WR cycle.
  assign mem_read_data = memArray[mem_address[3:0]];

  always @(posedge clock_in) begin
    if (tbInit) begin
      for (int i = 0; i < 16; i++) memArray[i] <= 32'h0;
      memArray[1] <= 32'h8000_80F1;
      memArray[2] <= 32'h0000_0002;
      memArray[3] <= 32'h1122_3344;
    end else if (mem_write) begin
      memArray[mem_address[3:0]] <= mem_write_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issues one request from IDLE and watches up to 8 cycles for its response.
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [31:0] addr, input logic [31:0] wd);
    logic seen;
    req_write = w; req_size = sz; req_signed = sg; req_address = addr; req_wdata = wd;
    req_valid = 1'b1;
    latency = 0; respErr = 0; respData = 0; rdCount = 0; wrCount = 0;
    lastWriteData = 0; strobeAddr = 0; addrUnstable = 0; bothStrobes = 0;
    seen = 1'b0;
    @(posedge clock_in);
    @(negedge clock_in);
    req_valid = 1'b0;
    req_address = 32'hFFFF_FFFF;
    req_wdata = ~wd;
    req_size = ~sz;
    for (int k = 1; k <= 8; k++) begin
      if (mem_read) rdCount++;
      if (mem_write) begin
        wrCount++;
        lastWriteData = mem_write_data;
      end
      if (mem_read || mem_write) begin
        if (!seen) begin
          strobeAddr = mem_address;
          seen = 1'b1;
        end else if (mem_address != strobeAddr) begin
          addrUnstable = 1;
        end
      end
      if (mem_read && mem_write) bothStrobes = 1;
      if (resp_valid) begin
        latency = k;
        respErr = {31'b0, resp_error};
        respData = resp_rdata;
        break;
      end
      @(negedge clock_in);
    end
    @(negedge clock_in);
  endtask

  logic [31:0] bpData [0:1];
  int          bpResp;
  int          bpAccepts;
  int          abortWrites;
  int          abortResps;

  initial begin
    reset = 1'b1; tbInit = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_address = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clock_in);
    checkOutput("resetReady",   32'(req_ready),  32'h0);
    checkOutput("resetRespVal", 32'(resp_valid), 32'h0);
    checkOutput("resetRdata",   resp_rdata,      32'h0);
    checkOutput("resetMemRd",   32'(mem_read),   32'h0);
    checkOutput("resetMemWr",   32'(mem_write),  32'h0);
    checkOutput("resetMemAddr", mem_address,     32'h0);
    reset = 1'b0; tbInit = 1'b0;
    @(negedge clock_in);
    checkOutput("readyAfterReset", 32'(req_ready), 32'h1);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    checkOutput("lwLatency", latency,    32'd2);
    checkOutput("lwRdCount", rdCount,    32'd1);
    checkOutput("lwWrCount", wrCount,    32'd0);
    checkOutput("lwAddr",    strobeAddr, 32'd1);
    checkOutput("lwErr",     respErr,    32'd0);
    checkOutput("lwData",    respData,   32'h8000_80F1);
    checkOutput("idleReady", 32'(req_ready), 32'h1);

    applyStimulus(1'b0, 2'b00, 1'b1, 32'h4, 32'h0);
    checkOutput("lbSigned",   respData, 32'hFFFF_FFF1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
    checkOutput("lbUnsigned", respData, 32'h0000_00F1);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
    checkOutput("lhSigned",   respData, 32'hFFFF_8000);
    checkOutput("lhLatency",  latency,  32'd2);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h4, 32'h0);
    checkOutput("lhUnsigned", respData, 32'h0000_80F1);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'h9, 32'h1234_56AB);
    checkOutput("sbLatency",  latency,       32'd3);
    checkOutput("sbRdCount",  rdCount,       32'd1);
    checkOutput("sbWrCount",  wrCount,       32'd1);
    checkOutput("sbWrData",   lastWriteData, 32'h0000_AB02);
    checkOutput("sbAddr",     strobeAddr,    32'd2);
    checkOutput("sbAddrStab", addrUnstable,  32'd0);
    checkOutput("sbNoBoth",   bothStrobes,   32'd0);
    checkOutput("sbHoldData", respData,      32'h0000_80F1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    checkOutput("sbReadBack", respData, 32'h0000_AB02);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    checkOutput("swLatency", latency,       32'd2);
    checkOutput("swRdCount", rdCount,       32'd0);
    checkOutput("swWrCount", wrCount,       32'd1);
    checkOutput("swWrData",  lastWriteData, 32'hDEAD_BEEF);
    checkOutput("swAddr",    strobeAddr,    32'd4);
    checkOutput("swHold",    respData,      32'h0000_AB02);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_5566);
    checkOutput("shLatency", latency,       32'd3);
    checkOutput("shWrData",  lastWriteData, 32'h5566_BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("shReadBack", respData, 32'h5566_BEEF);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    checkOutput("errLwLat",   latency,           32'd1);
    checkOutput("errLwFlag",  respErr,           32'd1);
    checkOutput("errLwStrb",  rdCount + wrCount, 32'd0);
    checkOutput("errLwHold",  respData,          32'h5566_BEEF);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_FFFF);
    checkOutput("errShLat",   latency,           32'd1);
    checkOutput("errShFlag",  respErr,           32'd1);
    checkOutput("errShStrb",  rdCount + wrCount, 32'd0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    checkOutput("errSzLat",   latency,           32'd1);
    checkOutput("errSzFlag",  respErr,           32'd1);
    checkOutput("errSzStrb",  rdCount + wrCount, 32'd0);
    checkOutput("errSzHold",  respData,          32'h5566_BEEF);
    checkOutput("mem3Before", memArray[3],       32'h1122_3344);

    // Back-to-back loads with req_valid held high throughout.
    bpResp = 0; bpAccepts = 0;
    bpData[0] = 32'h0; bpData[1] = 32'h0;
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_address = 32'h4;
    req_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (resp_valid) begin
        if (bpResp < 2) bpData[bpResp] = resp_rdata;
        bpResp++;
      end
      if (req_valid && req_ready) bpAccepts++;
      @(posedge clock_in);
      @(negedge clock_in);
      if (bpAccepts >= 1) begin
        req_size = 2'b01; req_signed = 1'b1; req_address = 32'h6;
      end
      if (bpAccepts >= 2) req_valid = 1'b0;
    end
    checkOutput("bpAccepts", 32'(bpAccepts), 32'd2);
    checkOutput("bpResps",   32'(bpResp),    32'd2);
    checkOutput("bpFirst",   bpData[0],      32'h8000_80F1);
    checkOutput("bpSecond",  bpData[1],      32'hFFFF_8000);

    // Reset during the read phase of a partial store.
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_address = 32'hC; req_wdata = 32'h0000_0077;
    req_valid = 1'b1;
    @(posedge clock_in);
    @(negedge clock_in);
    req_valid = 1'b0;
    checkOutput("abortInRd", 32'(mem_read), 32'h1);
    reset = 1'b1;
    abortWrites = 0; abortResps = 0;
    #1;
    checkOutput("abortReady", 32'(req_ready), 32'h0);
    checkOutput("abortRdata", resp_rdata,     32'h0);
    for (int c = 0; c < 3; c++) begin
      if (mem_write) abortWrites++;
      if (resp_valid) abortResps++;
      @(negedge clock_in);
    end
    reset = 1'b0;
    @(negedge clock_in);
    checkOutput("abortReadyAfter", 32'(req_ready), 32'h1);
    for (int c = 0; c < 3; c++) begin
      if (mem_write) abortWrites++;
      if (resp_valid) abortResps++;
      @(negedge clock_in);
    end
    checkOutput("abortNoWrite", 32'(abortWrites), 32'd0);
    checkOutput("abortNoResp",  32'(abortResps),  32'd0);
    checkOutput("abortMemKept", memArray[3],      32'h1122_3344);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 clock_in  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  pipeline presents a memory request.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 req_signed  input  1  sign-extend loads when 1, zero-extend when 0.
REQ-010 req_address  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  extended load result.
REQ-014 resp_error  output  1  misaligned or illegal-size request; valid with resp_valid.
REQ-015 mem_address  output  32  word index to data memory, = {2'b00, address[31:2]}.
REQ-016 mem_read  output  1  data memory read strobe.
REQ-017 mem_write  output  1  data memory write strobe.
REQ-018 mem_write_data  output  32  full word to write.
REQ-019 mem_read_data  input  32  word from data memory; valid at the rising edge ending the cycle in which mem_read is high.

Function
REQ-020 The FSM SHALL have five states: IDLE, RD, WR, RESP, ERR. req_ready SHALL be 1 only in IDLE.
REQ-021 Acceptance SHALL occur on a rising edge with req_valid && req_ready. All req_* fields SHALL be latched at acceptance and ignored otherwise.
REQ-022 Misalignment SHALL be defined as: half with address[0] = 1; word with address[1:0] != 0; size 11 is always illegal. Such a request SHALL go IDLE->ERR and SHALL produce no mem_read and no mem_write.
REQ-023 A load SHALL sequence IDLE->RD->RESP. mem_read = 1 only in RD, and mem_read_data SHALL be captured at the end of RD.
REQ-024 A word store SHALL sequence IDLE->WR->RESP. mem_write = 1 only in WR, with mem_write_data = req_wdata.
REQ-025 A byte or half store SHALL sequence IDLE->RD->WR->RESP (read-modify-write). In WR, only the addressed lane(s) of the captured word SHALL be replaced by req_wdata[7:0] or [15:0].
REQ-026 Byte lanes SHALL be little-endian: lane n = bits [8n+7:8n], with n = address[1:0]. A half access SHALL use lanes address[1]*2 and address[1]*2+1.
REQ-027 Load extraction SHALL take the selected byte/half from the captured word, sign- or zero-extended per req_signed. A word load SHALL pass through unchanged.
REQ-028 RESP and ERR SHALL each last exactly one cycle with resp_valid = 1, then return to IDLE.
REQ-029 resp_error SHALL be 1 in ERR and 0 in RESP.
REQ-030 resp_rdata SHALL update only for completed loads, and SHALL hold its value across stores, errors and idle cycles.
REQ-031 Latency from the acceptance edge to the resp_valid cycle SHALL be: error 1 cycle; load 2; word store 2; partial store 3.
REQ-032 mem_read and mem_write SHALL never be asserted in the same cycle. mem_address SHALL be stable throughout RD and WR.
REQ-033 mem_read, mem_write and resp_valid SHALL be decoded from registered state only, with no combinational path from req_*.
REQ-034 Only one request SHALL be outstanding at a time. req_valid while busy SHALL be held off by the requester and is not lost.

Reset
REQ-035 While reset = 1, the FSM SHALL be in IDLE and all outputs SHALL be 0, including req_ready, resp_rdata and the latched request.
REQ-036 Reset asserted mid-operation SHALL abort immediately: no further mem_write, and no resp_valid for the aborted request.
REQ-037 req_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-038 Word load: memory word 1 = 0x8000_80F1; load word at address 0x4 -> mem_read for 1 cycle with mem_address = 1; resp_valid 2 cycles after acceptance with resp_rdata = 0x8000_80F1.
REQ-039 Byte/half loads from the same word: signed byte at 0x4 -> 0xFFFF_FFF1; unsigned byte at 0x4 -> 0x0000_00F1; signed half at 0x6 -> 0xFFFF_8000; unsigned half at 0x4 -> 0x0000_80F1.
REQ-040 Partial store: word 2 = 0x0000_0002; store byte 0xAB to 0x9 -> RD, then WR with mem_write_data = 0x0000_AB02; resp_valid 3 cycles after acceptance; a following word load at 0x8 returns 0x0000_AB02.
REQ-041 Errors: word load at 0x6, half store at 0x3, and size 11 -> each gives resp_valid with resp_error = 1 one cycle after acceptance, with no mem strobes and resp_rdata unchanged.
REQ-042 Back-pressure: req_valid held high for two back-to-back loads -> second accepted only when req_ready returns in IDLE; both responses correct and in order.
REQ-043 Reset abort: assert reset during RD of a partial store -> no mem_write and no resp_valid; req_ready = 1 in the cycle after reset deasserts; memory unchanged.
